// File: rtl/ctrl_pipe_if.sv
// Control-pipe bundle: decoder inputs toward the pipe, per-stage control fields back out.
interface ctrl_pipe_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic [7:0]       ctrl_i;
    logic [REG_W-1:0] rs_i;
    logic [REG_W-1:0] rt_i;
    logic             flush_i;
    logic             stall_o;
    logic             ex_alusrc_o;
    logic [1:0]       ex_aluop_o;
    logic             ex_regdst_o;
    logic [REG_W-1:0] ex_rt_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             wb_regwrite_o;
    logic             wb_memtoreg_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport slave (
        input  ctrl_i, rs_i, rt_i, flush_i,
        output stall_o, ex_alusrc_o, ex_aluop_o, ex_regdst_o, ex_rt_o,
               mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o, bubble_cnt_o
    );

    modport master (
        output ctrl_i, rs_i, rt_i, flush_i,
        input  stall_o, ex_alusrc_o, ex_aluop_o, ex_regdst_o, ex_rt_o,
               mem_read_o, mem_write_o, wb_regwrite_o, wb_memtoreg_o, bubble_cnt_o
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries the decoder control bundle through ID/EX, EX/MEM, MEM/WB; detects load-use
// hazards, inserts bubbles on stall/flush and keeps a saturating bubble counter.
module ctrl_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    ctrl_pipe_if.slave bus
);
    logic [7:0]       idex_q;
    logic [7:0]       idex_d;
    logic [REG_W-1:0] idex_rt_q;
    logic [REG_W-1:0] idex_rt_d;
    logic [3:0]       exmem_q;
    logic [1:0]       memwb_q;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic             stall;
    logic             bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Load in EX writing a register that the ID instruction reads; $0 never creates a hazard.
    assign stall = idex_q[2] && (idex_rt_q != '0) &&
                   ((idex_rt_q == bus.rs_i) || (idex_rt_q == bus.rt_i));

    always_comb begin
        bubble       = stall | bus.flush_i;
        idex_d       = bubble ? 8'h00 : bus.ctrl_i;
        idex_rt_d    = bubble ? '0 : bus.rt_i;
        bubble_cnt_d = bubble ? sat_inc(bubble_cnt_q) : bubble_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_q       <= 8'h00;
            idex_rt_q    <= '0;
            exmem_q      <= 4'h0;
            memwb_q      <= 2'b00;
            bubble_cnt_q <= '0;
        end else begin
            idex_q       <= idex_d;
            idex_rt_q    <= idex_rt_d;
            exmem_q      <= idex_q[3:0];
            memwb_q      <= exmem_q[1:0];
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall_o       = stall;
    assign bus.ex_alusrc_o   = idex_q[4];
    assign bus.ex_aluop_o    = idex_q[6:5];
    assign bus.ex_regdst_o   = idex_q[7];
    assign bus.ex_rt_o       = idex_rt_q;
    assign bus.mem_read_o    = exmem_q[2];
    assign bus.mem_write_o   = exmem_q[3];
    assign bus.wb_regwrite_o = memwb_q[0];
    assign bus.wb_memtoreg_o = memwb_q[1];
    assign bus.bubble_cnt_o  = bubble_cnt_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: stimulus queues hand-computed output snapshots,
// a negedge monitor pops and compares them.
module tb_ctrl_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    ctrl_pipe_if #(.REG_W(5), .CNT_W(16)) bus ();

    ctrl_pipe #(.REG_W(5), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        alusrc;
        logic [1:0]  aluop;
        logic        regdst;
        logic [4:0]  ex_rt;
        logic        mr;
        logic        mw;
        logic        wr;
        logic        wm;
        logic [15:0] cnt;
    } out_t;

    out_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    function automatic out_t mk(input logic st, input logic as, input logic [1:0] op,
                                input logic rd, input logic [4:0] rt, input logic mr,
                                input logic mw, input logic wr, input logic wm,
                                input logic [15:0] cnt);
        out_t o;
        o = '{st, as, op, rd, rt, mr, mw, wr, wm, cnt};
        return o;
    endfunction

    // Drive one cycle of inputs just after the edge and queue what the outputs must show.
    task automatic step(input string nm, input logic [7:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic f, input out_t e);
        @(posedge clk);
        #1;
        bus.ctrl_i  = c;
        bus.rs_i    = rs;
        bus.rt_i    = rt;
        bus.flush_i = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor
    always @(negedge clk) begin
        out_t  act;
        out_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {bus.stall_o, bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_regdst_o, bus.ex_rt_o,
                   bus.mem_read_o, bus.mem_write_o, bus.wb_regwrite_o, bus.wb_memtoreg_o,
                   bus.bubble_cnt_o};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got st=%b as=%b op=%b rd=%b rt=%0d mr=%b mw=%b wr=%b wm=%b cnt=%h ; expected st=%b as=%b op=%b rd=%b rt=%0d mr=%b mw=%b wr=%b wm=%b cnt=%h",
                         nm, act.stall, act.alusrc, act.aluop, act.regdst, act.ex_rt, act.mr,
                         act.mw, act.wr, act.wm, act.cnt, e.stall, e.alusrc, e.aluop, e.regdst,
                         e.ex_rt, e.mr, e.mw, e.wr, e.wm, e.cnt);
            end
        end
    end

    out_t Z;

    initial begin
        Z = '0;
        bus.ctrl_i  = 8'h00;
        bus.rs_i    = 5'd0;
        bus.rt_i    = 5'd0;
        bus.flush_i = 1'b0;

        step("reset_state", 8'h00, 0, 0, 0, Z);
        @(negedge clk);
        #1 rst = 1'b0;

        // R-type 8'h51 flowing through all stages
        step("rtype_id",  8'h51, 1, 2, 0, Z);
        step("rtype_ex",  8'h00, 0, 0, 0, mk(0,1,2'b10,0,2, 0,0,0,0, 16'd0));
        step("rtype_mem", 8'h00, 0, 0, 0, Z);
        step("rtype_wb",  8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,1,0, 16'd0));
        step("rtype_idle",8'h00, 0, 0, 0, Z);

        // Load-use: lw rt=5 followed by a reader of $5
        step("lw_id",        8'h8F, 7, 5, 0, Z);
        step("lu_stall",     8'h51, 5, 3, 0, mk(1,0,2'b00,1,5, 0,0,0,0, 16'd0));
        step("lu_bubble",    8'h51, 5, 3, 0, mk(0,0,2'b00,0,0, 1,1,0,0, 16'd1));
        step("lu_held_ex",   8'h00, 0, 0, 0, mk(0,1,2'b10,0,3, 0,0,1,1, 16'd1));
        step("lu_drain1",    8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd1));
        step("lu_held_wb",   8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,1,0, 16'd1));
        step("lu_idle",      8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd1));

        // Load to $0 never stalls
        step("r0_lw",   8'h8F, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd1));
        step("r0_nost", 8'h00, 0, 0, 0, mk(0,0,2'b00,1,0, 0,0,0,0, 16'd1));
        step("r0_mem",  8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 1,1,0,0, 16'd1));
        step("r0_wb",   8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,1,1, 16'd1));
        step("r0_idle", 8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd1));

        // Flush kills 8'h91 in ID
        step("fl_id",  8'h91, 0, 4, 1, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd1));
        step("fl_ex",  8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd2));
        step("fl_mem", 8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd2));
        step("fl_wb",  8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd2));

        // Stall and flush together: one bubble, one count
        step("sf_lw",     8'h8F, 0, 6, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd2));
        step("sf_both",   8'h51, 6, 0, 1, mk(1,0,2'b00,1,6, 0,0,0,0, 16'd2));
        step("sf_bubble", 8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 1,1,0,0, 16'd3));
        step("sf_wb",     8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,1,1, 16'd3));
        step("sf_idle",   8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd3));

        // Fill every stage, then pulse reset between edges
        step("fill_a", 8'h8F, 0, 9,  0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'd3));
        step("fill_b", 8'h8F, 1, 10, 0, mk(0,0,2'b00,1,9, 0,0,0,0, 16'd3));
        step("fill_c", 8'h51, 2, 3,  0, mk(0,0,2'b00,1,10, 1,1,0,0, 16'd3));
        step("fill_d", 8'h91, 0, 4,  0, mk(0,1,2'b10,0,3, 1,1,1,1, 16'd3));
        step("async_rst", 8'h00, 0, 0, 0, Z);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        step("post_rst", 8'h00, 0, 0, 0, Z);

        // Counter saturation under continuous flush
        step("sat_start", 8'h00, 0, 0, 1, Z);
        repeat (65533) @(posedge clk);
        step("sat_fffe", 8'h00, 0, 0, 1, mk(0,0,2'b00,0,0, 0,0,0,0, 16'hFFFE));
        step("sat_ffff", 8'h00, 0, 0, 1, mk(0,0,2'b00,0,0, 0,0,0,0, 16'hFFFF));
        step("sat_hold", 8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'hFFFF));
        step("sat_keep", 8'h00, 0, 0, 0, mk(0,0,2'b00,0,0, 0,0,0,0, 16'hFFFF));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d snapshots left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the opcode decoder's 8-bit control bundle.
- Carries the bundle from ID through the ID/EX, EX/MEM and MEM/WB pipeline registers, and hands each stage only the fields it uses.
- Detects load-use hazards and inserts bubbles on stall or flush (taken branch/jump).
- Keeps a saturating bubble counter for performance debug.

Parameters:
- REG_W, 5, register-specifier width.
- CNT_W, 16, bubble counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- ctrl_i  input  8  decoder bundle. Bit meanings:
  - [0] RegWrite, [1] MemtoReg
  - [2] MemRead, [3] MemWrite
  - [4] ALUSrc, [6:5] ALUOp, [7] RegDst
- rs_i  input  REG_W  rs field of the instruction in ID.
- rt_i  input  REG_W  rt field of the instruction in ID.
- flush_i  input  1  kill the instruction in ID (branch/jump taken).
- stall_o  output  1  load-use hazard; PC and IF/ID must hold.
- ex_alusrc_o  output  1  ID/EX bit 4.
- ex_aluop_o  output  2  ID/EX bits 6:5.
- ex_regdst_o  output  1  ID/EX bit 7.
- ex_rt_o  output  REG_W  rt held in ID/EX.
- mem_read_o  output  1  EX/MEM bit 2.
- mem_write_o  output  1  EX/MEM bit 3.
- wb_regwrite_o  output  1  MEM/WB bit 0.
- wb_memtoreg_o  output  1  MEM/WB bit 1.
- bubble_cnt_o  output  CNT_W  count of bubbles inserted.

Behaviour:
- State:
  - idex_q[7:0] and idex_rt_q[REG_W-1:0]
  - exmem_q[3:0]
  - memwb_q[1:0]
  - bubble counter
- Reset: while rst_i is high, all state is asynchronously cleared to 0.
  - Every output reads 0, including stall_o, because idex_q is 0.
  - Asserting reset mid-stream discards all in-flight control and clears the counter.
- stall_o is combinational. It is 1 iff all of the following hold:
  - idex_q[2] = 1
  - idex_rt_q != 0
  - idex_rt_q == rs_i or idex_rt_q == rt_i
- ID/EX update each edge:
  - If stall_o or flush_i: load idex_q = 0 and idex_rt_q = 0 (bubble).
  - Otherwise: load idex_q = ctrl_i and idex_rt_q = rt_i.
- EX/MEM and MEM/WB update every edge, with no enable:
  - exmem_q <= idex_q[3:0]
  - memwb_q <= exmem_q[1:0]
  - Bubbles drain down the pipe naturally.
- Latency: for ctrl_i sampled at edge N (no stall, no flush):
  - EX fields are visible after edge N.
  - MEM fields after N+1.
  - WB fields after N+2.
- Stall lasts exactly one cycle per lw. The bubble clears idex_q[2], so stall_o deasserts on the next cycle unless the new ID/EX occupant is itself a load. Back-to-back stalls cannot arise from a single lw.
- Stall and flush in the same cycle produce one bubble and increment the counter by 1 only.
- Bubble counter: increments by 1 on each edge where stall_o or flush_i is 1. It saturates at 2^CNT_W-1 and does not wrap.
- ctrl_i values with undefined opcodes (all zero from the decoder) pass through as a natural no-op. No special case is needed.

Test Plan:
- Reset, then drive ctrl_i=8'h51 (R-type), rs=1, rt=2 for one edge, then 8'h00 → after edge 1: ex_alusrc=1, ex_aluop=2'b10, ex_regdst=0; after edge 3: wb_regwrite=1, wb_memtoreg=0; stall_o=0 throughout, bubble_cnt=0.
- Load-use: lw (8'h8F, rt=5) then next instruction rs=5, rt=3 → stall_o=1 for exactly one cycle. ID/EX holds 0 that cycle, mem_read_o=1 the following cycle. bubble_cnt=1; the held instruction enters EX one cycle later with its own fields.
- Register-0 exclusion: lw with rt=0 followed by rs=0 → stall_o stays 0, no bubble.
- Flush: drive ctrl_i=8'h91 with flush_i=1 → after edge: ex_regdst=0, ex_alusrc=0; two edges later wb_regwrite=0; bubble_cnt=1.
- Simultaneous stall and flush in one cycle → one bubble, bubble_cnt increments by exactly 1.
- Async reset pulse mid-stream, asserted between clock edges with nonzero state in all stages → all outputs 0 immediately, before the next edge. Counter preloaded near 16'hFFFF by forcing flush for 65536+ edges → saturates at 16'hFFFF and holds.
